mont_exp: RTL
=============

// Module: mont_exp
// PURPOSE
//  Modular exponentiator: computes result = base^exp mod m, all values in the Montgomery domain (R = 2^WIDTH).
//  Sits directly upstream of the montgomery multiplier and drives it through its start/done handshake.
//  Main use in ECDSA verify: modular inverse s^-1 = s^(n-2) mod n, by Fermat's little theorem.
//  Operands arrive already in Montgomery form. Conversion into and out of the domain happens outside this block.
// PARAMETERS
//  WIDTH      381  operand/modulus width; must equal the multiplier width
//  EXP_WIDTH  381  exponent width; number of exponent bits scanned
// PORTS
//  clk         in   1          clock
//  resetn      in   1          asynchronous, active-low reset
//  start       in   1          1-cycle request; sampled only in IDLE
//  in_base     in   WIDTH      base in Montgomery form (x*R mod m)
//  in_one      in   WIDTH      Montgomery one (R mod m)
//  in_exp      in   EXP_WIDTH  exponent, plain binary
//  in_m        in   WIDTH      odd modulus
//  busy        out  1          high from the cycle after start is accepted until done
//  done        out  1          1-cycle pulse; result valid from this cycle on
//  result      out  WIDTH      base^exp * R mod m; held until the next accepted start
//  mul_start   out  1          1-cycle pulse to the multiplier
//  mul_a       out  WIDTH      multiplier operand a (registered)
//  mul_b       out  WIDTH      multiplier operand b (registered)
//  mul_m       out  WIDTH      multiplier modulus; equals the latched in_m
//  mul_result  in   WIDTH      multiplier output a*b*R^-1 mod m; valid only in the mul_done cycle
//  mul_done    in   1          1-cycle pulse from the multiplier
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, mul_start=0; result, acc, mul_a, mul_b, all latched operands=0.
//  Algorithm: left-to-right square-and-multiply. acc=in_one; for i=EXP_WIDTH-1 downto 0: acc=acc*acc; if exp[i], acc=acc*base.
//  No leading-zero skip: always EXP_WIDTH squarings plus popcount(exp) multiplies.
//  Operation count is data-dependent on exponent weight only.
//  FSM states: IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, FINISH.
//   IDLE:      on start, latch base/one/exp/m; acc<=in_one; bit counter<=EXP_WIDTH-1; go to SQ_ISSUE.
//   SQ_ISSUE:  mul_a=mul_b=acc; mul_start=1 for exactly this cycle; go to SQ_WAIT.
//   SQ_WAIT:   on mul_done, acc<=mul_result. If exp[cnt], go to MUL_ISSUE; else go to STEP logic.
//   MUL_ISSUE: mul_a=acc, mul_b=base; mul_start=1; go to MUL_WAIT.
//   MUL_WAIT:  on mul_done, acc<=mul_result, then STEP logic.
//   STEP:      if cnt==0, go to FINISH; else cnt<=cnt-1 and go to SQ_ISSUE.
//   FINISH:    result<=acc; done=1 for 1 cycle; go to IDLE.
//  mul_result is captured only in the mul_done cycle, because the multiplier clears its output afterwards.
//  The next mul_start comes no earlier than 1 cycle after mul_done, so the multiplier is back in idle.
//  start while busy: ignored; latched operands do not change.
//  start in the FINISH cycle: ignored. It is accepted the following cycle, when the FSM is in IDLE.
//  mul_done outside SQ_WAIT/MUL_WAIT: ignored. Simulation assertion fires.
//  exp=0: result=in_one after EXP_WIDTH squarings.
//  exp=1: result=in_base.
//  Reset mid-operation: immediate return to IDLE and all reset values; mul_start drops asynchronously.
//   The multiplier shares resetn, so both blocks restart clean.
//  Bit counter: ceil(log2(EXP_WIDTH)) bits wide; never wraps, because STEP tests cnt==0 before decrementing.
// STRUCTURE
//  Shared package: WIDTH/EXP_WIDTH constants, FSM state encoding, exported multiplier port widths.
//  No sub-module inside. The montgomery multiplier is instantiated next to this block by the parent;
//   a wrapper mont_exp_top ties the two together for test.
// TESTING (bench uses behavioural multiplier model: a*b*R^-1 mod m, done latency 3..400 cycles, randomised)
//  1. m=29, base=5*R mod 29, one=R mod 29, exp=27 -> result*1 (via model) == 6;
//     exactly 385 mul_start pulses (381 sq + 4 mul).
//  2. exp=0 -> result == in_one; 381 mul_start pulses; done pulse exactly 1 cycle wide.
//  3. exp=1 -> result == in_base.
//     exp=2^380 -> 382 pulses; result == base^(2^380) mod m (model reference).
//  4. n = secp384r1-style 381-bit odd m, exp=m-2, random base -> (result*base*R^-1 mod m) == one; busy high throughout.
//  5. start pulsed 5 times while busy, plus a spurious mul_done in SQ_ISSUE -> result unchanged vs test 1; assertion logged.
//  6. resetn low mid-SQ_WAIT -> all outputs 0 next edge;
//     new start with test-1 operands -> result == 6*R mod 29.

Source files
------------

// File: rtl/mont_exp_pkg.sv
// Shared definitions for the Montgomery-domain modular exponentiator:
// default widths, the multiplier port widths it exports, and the FSM encoding.
package mont_exp_pkg;

    localparam int unsigned MONT_WIDTH     = 381;
    localparam int unsigned MONT_EXP_WIDTH = 381;

    // Widths of the multiplier interface driven by the exponentiator.
    localparam int unsigned MUL_OPERAND_W = MONT_WIDTH;
    localparam int unsigned MUL_MODULUS_W = MONT_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQ_ISSUE,
        ST_SQ_WAIT,
        ST_MUL_ISSUE,
        ST_MUL_WAIT,
        ST_FINISH
    } state_e;

    // Bit counter width; at least one bit even for a single-bit exponent.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mont_exp.sv
// Left-to-right square-and-multiply exponentiator in the Montgomery domain.
// Drives an external Montgomery multiplier through its start/done handshake;
// every exponent bit costs one squaring, set bits cost one extra multiply.
module mont_exp
    import mont_exp_pkg::*;
#(
    parameter int unsigned WIDTH     = MONT_WIDTH,
    parameter int unsigned EXP_WIDTH = MONT_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_base,
    input  logic [WIDTH-1:0]     in_one,
    input  logic [EXP_WIDTH-1:0] in_exp,
    input  logic [WIDTH-1:0]     in_m,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [WIDTH-1:0]     mul_m,
    input  logic [WIDTH-1:0]     mul_result,
    input  logic                 mul_done
);

    localparam int unsigned   CW      = cnt_width(EXP_WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(EXP_WIDTH - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     base_q, base_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic                 do_step;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            base_q   <= '0;
            m_q      <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            m_q      <= m_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
        end
    end

    // Next-state logic; multiplier operands are prepared one cycle ahead so
    // they are already registered when the issue state raises mul_start.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        m_d      = m_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        do_step  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = in_base;
                    exp_d   = in_exp;
                    m_d     = in_m;
                    acc_d   = in_one;
                    cnt_d   = CNT_TOP;
                    mul_a_d = in_one;
                    mul_b_d = in_one;
                    state_d = ST_SQ_ISSUE;
                end
            end
            ST_SQ_ISSUE: state_d = ST_SQ_WAIT;
            ST_SQ_WAIT: begin
                if (mul_done) begin
                    acc_d = mul_result;
                    if (exp_q[cnt_q]) begin
                        mul_a_d = mul_result;
                        mul_b_d = base_q;
                        state_d = ST_MUL_ISSUE;
                    end else begin
                        do_step = 1'b1;
                    end
                end
            end
            ST_MUL_ISSUE: state_d = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    acc_d   = mul_result;
                    do_step = 1'b1;
                end
            end
            ST_FINISH: begin
                result_d = acc_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Counter is tested before decrementing, so it never wraps. The result
        // is loaded on entry to FINISH so it is valid in the done cycle.
        if (do_step) begin
            if (cnt_q == '0) begin
                result_d = acc_d;
                state_d  = ST_FINISH;
            end else begin
                cnt_d   = cnt_q - CW'(1);
                mul_a_d = acc_d;
                mul_b_d = acc_d;
                state_d = ST_SQ_ISSUE;
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);
    assign mul_start = (state_q == ST_SQ_ISSUE) || (state_q == ST_MUL_ISSUE);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_m     = m_q;
    assign result    = result_q;

    // Flag multiplier completions that arrive when nothing is outstanding.
    always_ff @(posedge clk) begin
        if (resetn && mul_done) begin
            assert (state_q == ST_SQ_WAIT || state_q == ST_MUL_WAIT)
            else $warning("mont_exp: mul_done outside a wait state ignored");
        end
    end

endmodule
